dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits directly downstream of the ALU: the ALU result is the load/store byte address.
- Serves loads from a local line store and refills misses from main memory over a req/ack handshake.
- Stalls the core while a refill or a write-through is outstanding.

Parameters:
- INDEX_BITS, 5, line index width; NUM_LINES = 2^INDEX_BITS = 32.
- OFFSET_BITS, 2, word-in-line width; WORDS_PER_LINE = 4; tag = 32 - 2 - OFFSET_BITS - INDEX_BITS = 23 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Addr  input  32  byte address from ALUResult; bits [1:0] ignored (word access only)
- WData  input  32  store data
- MemRead  input  1  load request
- MemWrite  input  1  store request
- RData  output  32  load data
- Stall  output  1  core must hold PC, Addr, WData, MemRead and MemWrite stable while high
- mem_addr  output  32  word-aligned memory address
- mem_wdata  output  32  memory write data
- mem_rd  output  1  memory read request, held until mem_ack
- mem_wr  output  1  memory write request, held until mem_ack
- mem_ack  input  1  one-cycle acknowledge; on a read it qualifies mem_rdata
- mem_rdata  input  32  memory read data

Behaviour:
- Reset, synchronous on the clk edge with rst=1:
  - state = IDLE; all valid bits = 0; beat counter = 0.
  - Outputs: Stall=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, RData=0.
  - Tag and data arrays are not reset.
- Address decode:
  - tag = Addr[31:9]
  - index = Addr[8:4]
  - offset = Addr[3:2]
- hit = valid[index] && tag_array[index] == tag.
- States: IDLE, REFILL, WRITE, WDONE.
- IDLE:
  - MemWrite=1, which has priority over MemRead: Stall=1 combinationally; next state WRITE.
  - MemRead=1 and hit: RData = data[index][offset] combinationally, Stall=0; zero-cycle latency; stay IDLE.
  - MemRead=1 and miss: Stall=1; beat=0; next state REFILL.
  - Neither request: Stall=0, RData=0.
  - mem_ack is ignored in IDLE.
- REFILL:
  - Stall=1; mem_rd=1; mem_addr = {tag, index, beat, 2'b00}.
  - On each mem_ack, store mem_rdata into data[index][beat] and increment beat.
  - On the 4th ack (beat=3), write tag_array[index], set valid[index]=1, and go to IDLE.
  - The next cycle is a hit: Stall=0 and RData valid.
  - Minimum miss penalty is 5 cycles with immediate acks.
- WRITE:
  - Stall=1; mem_wr=1; mem_addr = {Addr[31:2], 2'b00}; mem_wdata = WData.
  - On mem_ack, if hit, update data[index][offset] = WData (valid and tag unchanged); a miss does not allocate.
  - On mem_ack, go to WDONE.
- WDONE:
  - Stall=0 for exactly one cycle so the core retires the store; no memory request; next state IDLE.
  - A back-to-back store in the next instruction re-enters WRITE from IDLE.
- Memory request rules:
  - mem_rd and mem_wr are never high together.
  - mem_addr and mem_wdata are stable while a request is high.
- Reset mid-REFILL: the line's valid bit was never set, so the line stays invalid and the partial data is harmless.
- Reset mid-WRITE: the request is dropped and memory may or may not have committed it.
- Request inputs changing while Stall=1 is a core protocol violation; behaviour is undefined.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, the block adds output ports hit_count [31:0] and miss_count [31:0]. Both reset to 0 and saturate at 32'hFFFFFFFF.
- miss_count increments on every IDLE→REFILL transition.
- hit_count increments on every read that completes in IDLE with hit=1 and no immediately preceding refill. The refill-completion cycle is excluded, so each load counts exactly once.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 2 cycles, then a read of Addr=0x100 → miss, Stall=1, mem_rd=1, mem_addr 0x100, 0x104, 0x108, 0x10C in sequence.
- Cold read miss: MemRead at 0x104, memory returns 0xA0,0xA1,0xA2,0xA3 with immediate acks → refill completes, next cycle Stall=0 and RData=0xA1. Then a read at 0x10C hits with RData=0xA3 and Stall=0 in the same cycle.
- Write hit: after the line above is loaded, MemWrite 0x108 with WData 0xDEAD, mem_ack after 3 cycles → mem_wr held 3 cycles, WDONE Stall=0 for 1 cycle. A subsequent read of 0x108 hits and returns 0xDEAD.
- Write miss: MemWrite 0x2000 with 0x55 → mem_wr issued with no allocation. A subsequent read of 0x2000 misses and refills.
- Conflict eviction: read 0x0000, then 0x0200 (same index 0, different tag), then 0x0000 again → three refills; RData matches the memory contents each time.
- Reset mid-refill: assert rst after the 2nd ack of a refill of 0x300 → Stall=0, mem_rd=0. A re-read of 0x300 misses and performs a full 4-beat refill.
- With DCACHE_STATS_EN: 1 miss plus 3 hits → miss_count=1, hit_count=3.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller placed behind the ALU. Loads hit in zero cycles from the local
// line store. Misses refill a whole line from main memory one word per
// mem_ack. Stores are always written through to memory.
//
// Optional feature: define DCACHE_STATS_EN to add the hit_count/miss_count
// output ports and their saturating counters.
//
// Memory handshake: mem_rd / mem_wr is a request that stays high, with
// mem_addr and mem_wdata stable, until the single-cycle mem_ack. The
// request is taken in the cycle where both the request and mem_ack are
// high. mem_rdata is only meaningful on an ack of a read. Core side: the
// core holds Addr, WData, MemRead and MemWrite stable while Stall is high.
// An access retires on a rising edge where Stall is low.
module dcache_ctrl #(
  parameter int INDEX_BITS  = 5,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] RData,
  output logic        Stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int NUM_LINES      = 1 << INDEX_BITS;
  localparam int WORDS_PER_LINE = 1 << OFFSET_BITS;
  localparam int TAG_BITS       = 32 - 2 - OFFSET_BITS - INDEX_BITS;
  localparam int WORD_IDX_BITS  = INDEX_BITS + OFFSET_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_WDONE  = 2'd3
  } state_t;

  // FSM state register. Name it state_q when binding checkers.
  state_t                  state_q, state_d;
  logic [OFFSET_BITS-1:0]  beat_q, beat_d;
  logic [NUM_LINES-1:0]    valid_q;

  // Tag and data stores carry no reset. The valid bits alone decide
  // whether their contents mean anything.
  logic [TAG_BITS-1:0]     tag_array  [NUM_LINES];
  logic [31:0]             data_array [NUM_LINES*WORDS_PER_LINE];

  // Address decode. Byte-lane bits are masked off here, so every later use
  // sees a word-aligned address.
  logic [31:0]             word_addr;
  logic [TAG_BITS-1:0]     addr_tag;
  logic [INDEX_BITS-1:0]   addr_index;
  logic [OFFSET_BITS-1:0]  addr_offset;
  logic [WORD_IDX_BITS-1:0] access_idx;
  logic [WORD_IDX_BITS-1:0] fill_idx;
  logic [31:0]             refill_addr;
  logic                    hit;

  // Write enables produced by the FSM for the array and valid updates.
  logic                    refill_we;
  logic                    fill_done;
  logic                    store_we;

  assign word_addr   = Addr & 32'hFFFF_FFFC;
  assign addr_tag    = word_addr[31 -: TAG_BITS];
  assign addr_index  = word_addr[2+OFFSET_BITS +: INDEX_BITS];
  assign addr_offset = word_addr[2 +: OFFSET_BITS];
  assign access_idx  = {addr_index, addr_offset};
  assign fill_idx    = {addr_index, beat_q};
  assign refill_addr = {addr_tag, addr_index, beat_q, 2'b00};
  assign hit         = valid_q[addr_index] && (tag_array[addr_index] == addr_tag);

  // Next-state, handshake outputs and array write enables.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    Stall     = 1'b0;
    RData     = 32'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    refill_we = 1'b0;
    fill_done = 1'b0;
    store_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Stores win over loads. mem_ack is ignored here.
        if (MemWrite) begin
          Stall   = 1'b1;
          state_d = S_WRITE;
        end else if (MemRead) begin
          if (hit) begin
            RData = data_array[access_idx];
          end else begin
            Stall   = 1'b1;
            beat_d  = '0;
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        Stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = refill_addr;
        if (mem_ack) begin
          refill_we = 1'b1;
          beat_d    = beat_q + 1'b1;
          // The last beat installs the tag and valid bit. The load then hits
          // in the next IDLE cycle.
          if (&beat_q) begin
            fill_done = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        Stall     = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = WData;
        if (mem_ack) begin
          // A store hit updates the cached word. A store miss does not
          // allocate a line.
          store_we = hit;
          state_d  = S_WDONE;
        end
      end
      S_WDONE: begin
        // One unstalled cycle lets the core retire the store before IDLE
        // looks at the request lines again.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, beat counter and valid bits. A reset part-way through a refill
  // leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (fill_done) begin
        valid_q[addr_index] <= 1'b1;
      end
    end
  end

  // Tag/data array writes. These are blocked while reset is high so that an
  // abandoned transfer cannot change the store.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill_we) begin
        data_array[fill_idx] <= mem_rdata;
      end
      if (fill_done) begin
        tag_array[addr_index] <= addr_tag;
      end
      if (store_we) begin
        data_array[access_idx] <= WData;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        fill_prev_q;

  // Saturating access counters. The IDLE cycle right after a refill is the
  // same load completing, so that cycle is not counted as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
      fill_prev_q <= 1'b0;
    end else begin
      fill_prev_q <= fill_done;
      if (state_q == S_IDLE && MemRead && !MemWrite) begin
        if (!hit) begin
          if (miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
          end
        end else if (!fill_prev_q) begin
          if (hit_cnt_q != 32'hFFFF_FFFF) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
          end
        end
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl. A memory responder gives acks after a
// configurable delay. The load/store tasks predict hit or miss from a map of
// resident line base addresses, and they predict data from a main-memory map.
module tb_dcache_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] Addr = 32'd0;
  logic [31:0] WData = 32'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] RData;
  logic        Stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .WData     (WData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .RData     (RData),
    .Stall     (Stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int hit_exp = 0;
  int miss_exp = 0;
  int ack_delay = 0;

  logic [31:0] mem_model [logic [31:0]];   // main memory contents
  logic [31:0] resident  [int];            // index -> resident line base
  logic [31:0] rd_q[$];                    // observed read-beat addresses
  logic [31:0] wr_q[$];                    // observed write addresses
  logic [31:0] exp_q[$];                   // expected read-beat addresses

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    logic        armed;
    int          cnt;
    logic [31:0] arm_addr;
    logic [31:0] arm_wdata;
    armed = 1'b0;
    cnt = 0;
    arm_addr = 32'd0;
    arm_wdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst) begin
        armed = 1'b0;
      end else if (mem_rd || mem_wr) begin
        check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        if (!armed) begin
          armed = 1'b1;
          cnt = ack_delay;
          arm_addr = mem_addr;
          arm_wdata = mem_wdata;
        end else begin
          check("req_addr_stable", mem_addr, arm_addr);
          check("req_wdata_stable", mem_wdata, arm_wdata);
        end
        if (cnt == 0) begin
          mem_ack = 1'b1;
          armed = 1'b0;
          if (mem_rd) begin
            mem_rdata = mem_word(mem_addr);
            rd_q.push_back(mem_addr);
          end else begin
            mem_model[mem_addr] = mem_wdata;
            wr_q.push_back(mem_addr);
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Addr = 32'd0;
    WData = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_mem_req", 32'({mem_rd, mem_wr}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", RData, 32'd0);
    rst = 1'b0;
    resident.delete();
    hit_exp = 0;
    miss_exp = 0;
  endtask

  task automatic do_idle();
    @(negedge clk);
    MemRead = 1'b0;
    MemWrite = 1'b0;
    #1;
    check("idle_stall", 32'(Stall), 32'd0);
    check("idle_rdata", RData, 32'd0);
    check("idle_mem_req", 32'({mem_rd, mem_wr}), 32'd0);
    @(posedge clk);
  endtask

  task automatic do_load(input logic [31:0] a, input int dly);
    logic [31:0] base;
    logic [31:0] exp;
    int          idx;
    int          stalls;
    logic        hit_pred;
    ack_delay = dly;
    rd_q.delete();
    exp_q.delete();
    base = a & 32'hFFFF_FFF0;
    idx = int'((a >> 4) % 32);
    exp = mem_word(a & 32'hFFFF_FFFC);
    hit_pred = resident.exists(idx) && resident[idx] == base;
    @(negedge clk);
    Addr = a;
    MemRead = 1'b1;
    MemWrite = 1'b0;
    #1;
    check("ld_first_stall", 32'(Stall), 32'(!hit_pred));
    stalls = 0;
    while (Stall === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (!hit_pred) begin
      check("ld_miss_stalls", stalls, 1 + 4 * (dly + 1));
      check("ld_beat_count", rd_q.size(), 4);
      for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
      while (exp_q.size() > 0 && rd_q.size() > 0)
        check("ld_beat_addr", rd_q.pop_front(), exp_q.pop_front());
      resident[idx] = base;
      miss_exp++;
    end else begin
      hit_exp++;
    end
    check("ld_rdata", RData, exp);
    check("ld_done_mem_req", 32'({mem_rd, mem_wr}), 32'd0);
    @(posedge clk);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int dly);
    int stalls;
    int wr_cycles;
    ack_delay = dly;
    wr_q.delete();
    @(negedge clk);
    Addr = a;
    WData = d;
    MemWrite = 1'b1;
    MemRead = 1'b0;
    #1;
    check("st_first_stall", 32'(Stall), 32'd1);
    stalls = 0;
    wr_cycles = 0;
    while (Stall === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
      if (mem_wr === 1'b1) wr_cycles++;
    end
    check("st_stall_cycles", stalls, dly + 2);
    check("st_wr_cycles", wr_cycles, dly + 1);
    check("st_wdone_mem_req", 32'({mem_rd, mem_wr}), 32'd0);
    check("st_wr_addr", (wr_q.size() == 1) ? wr_q[0] : 32'hFFFF_FFFF, a & 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    // Store still presented: WDONE is over and IDLE re-enters a write.
    check("st_wdone_one_cycle", 32'(Stall), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    logic [31:0] a;
    int op;
    for (int i = 0; i < 4; i++) mem_model[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);

    do_reset();
    // Cold miss, then a hit in the same line.
    do_load(32'h104, 0);
    do_load(32'h10C, 0);
    // Write hit with a delayed ack, then read back the new data.
    do_store(32'h108, 32'hDEAD, 2);
    do_load(32'h108, 0);
    // Write miss does not allocate: the following read refills.
    do_store(32'h2000, 32'h55, 1);
    do_load(32'h2000, 0);
    do_idle();
    // Conflict eviction on index 0.
    do_load(32'h0000, 1);
    do_load(32'h0200, 0);
    do_load(32'h0000, 3);

    // Reset after the second beat of a refill.
    ack_delay = 0;
    rd_q.delete();
    @(negedge clk);
    Addr = 32'h300;
    MemRead = 1'b1;
    MemWrite = 1'b0;
    n = 0;
    #1;
    while (rd_q.size() < 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mr_two_acks", rd_q.size(), 2);
    rst = 1'b1;
    MemRead = 1'b0;
    @(negedge clk);
    #1;
    check("mr_stall", 32'(Stall), 32'd0);
    check("mr_mem_rd", 32'(mem_rd), 32'd0);
    rst = 1'b0;
    resident.delete();
    hit_exp = 0;
    miss_exp = 0;
    do_load(32'h300, 1);
    do_load(32'h304, 0);
    do_load(32'h308, 0);
    do_load(32'h30C, 0);

    // Randomized mix over a small tag/index pool to get hits and conflicts.
    for (int i = 0; i < 250; i++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      op = int'($urandom_range(0, 9));
      if (op < 6) do_load(a, int'($urandom_range(0, 3)));
      else if (op < 9) do_store(a, $urandom, int'($urandom_range(0, 3)));
      else do_idle();
    end
    do_idle();

`ifdef DCACHE_STATS_EN
    check("stats_miss_count", miss_count, 32'(miss_exp));
    check("stats_hit_count", hit_count, 32'(hit_exp));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
